// File: rtl/mac_accum_if.sv
// Operand/result bundle for the mac_accum multiply-accumulate stage.
// The master side drives operands and clr; the slave side returns the completed sum.
interface mac_accum_if #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned ACC_WIDTH = 24
);
  logic                        in_valid;
  logic signed [BUS_WIDTH-1:0] a;
  logic signed [BUS_WIDTH-1:0] b;
  logic                        clr;
  logic                        out_valid;
  logic signed [ACC_WIDTH-1:0] result;
  logic                        overflow;
  logic                        busy;

  modport master (
    output in_valid, a, b, clr,
    input  out_valid, result, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, clr,
    output out_valid, result, overflow, busy
  );
endinterface

// File: rtl/mac_accum.sv
// Two-stage signed MAC: registers a*b, then accumulates COUNT products with saturation
// and strobes the completed dot product for one cycle before restarting.
module mac_accum #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned ACC_WIDTH = 24,
  parameter int unsigned COUNT     = 8
) (
  input logic        clk,
  input logic        rst,
  mac_accum_if.slave bus
);

  localparam int unsigned ProdW = 2 * BUS_WIDTH;
  localparam int unsigned CntW  = $clog2(COUNT + 1);
  localparam bit SingleProd     = (COUNT == 1);

  localparam logic signed [ACC_WIDTH:0] SatMax = {2'b00, {(ACC_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SatMin = {2'b11, {(ACC_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } state_e;

  state_e                      state_q, state_d;
  logic signed [ProdW-1:0]     p1_q, p1_d;
  logic                        v1_q, v1_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic                        sat_q, sat_d;
  logic signed [ACC_WIDTH-1:0] result_q, result_d;
  logic                        overflow_q, overflow_d;

  logic signed [ProdW-1:0]     prod;
  logic signed [ACC_WIDTH:0]   prod_ext;
  logic signed [ACC_WIDTH:0]   sum_raw;
  logic signed [ACC_WIDTH:0]   sum_sat;
  logic                        sum_clamped;
  logic [CntW-1:0]             cnt_inc;
  logic                        cnt_last;

  // Datapath: product, guarded sum and clamp
  assign prod     = bus.a * bus.b;
  assign prod_ext = {{(ACC_WIDTH + 1 - ProdW){p1_q[ProdW-1]}}, p1_q};
  assign sum_raw  = {acc_q[ACC_WIDTH-1], acc_q} + prod_ext;
  assign cnt_inc  = cnt_q + CntW'(1);
  assign cnt_last = (cnt_inc == CntW'(COUNT));

  always_comb begin
    sum_sat     = sum_raw;
    sum_clamped = 1'b0;
    if (sum_raw > SatMax) begin
      sum_sat     = SatMax;
      sum_clamped = 1'b1;
    end else if (sum_raw < SatMin) begin
      sum_sat     = SatMin;
      sum_clamped = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      p1_q       <= '0;
      v1_q       <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      p1_q       <= p1_d;
      v1_q       <= v1_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    p1_d       = p1_q;
    v1_d       = 1'b0;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    result_d   = result_q;
    overflow_d = overflow_q;

    if (bus.clr) begin
      // Abort wins over everything, including a completion due this edge
      state_d = StIdle;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else begin
      if (bus.in_valid) begin
        p1_d = prod;
        v1_d = 1'b1;
      end

      unique case (state_q)
        StIdle, StDone: begin
          if (v1_q) begin
            // The first product always fits, so it loads without clamping
            acc_d   = prod_ext[ACC_WIDTH-1:0];
            cnt_d   = CntW'(1);
            sat_d   = 1'b0;
            state_d = StAccum;
            if (SingleProd) begin
              result_d   = prod_ext[ACC_WIDTH-1:0];
              overflow_d = 1'b0;
              acc_d      = '0;
              cnt_d      = '0;
              state_d    = StDone;
            end
          end else begin
            state_d = StIdle;
          end
        end

        StAccum: begin
          if (v1_q) begin
            acc_d = sum_sat[ACC_WIDTH-1:0];
            sat_d = sat_q | sum_clamped;
            cnt_d = cnt_inc;
            if (cnt_last) begin
              result_d   = sum_sat[ACC_WIDTH-1:0];
              overflow_d = sat_q | sum_clamped;
              acc_d      = '0;
              cnt_d      = '0;
              state_d    = StDone;
            end
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.out_valid = (state_q == StDone);
    bus.result    = result_q;
    bus.overflow  = overflow_q;
    bus.busy      = v1_q | (state_q == StAccum);
  end

endmodule

// File: tb/tb_mac_accum.sv
// Self-checking bench for mac_accum: a default instance and a narrow saturating instance,
// each compared cycle by cycle against a dot-product reference model.
module tb_mac_accum;

  localparam int unsigned BW   = 8;
  localparam int unsigned AW0  = 24;
  localparam int unsigned CNT0 = 8;
  localparam int unsigned AW1  = 16;
  localparam int unsigned CNT1 = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mac_accum_if #(.BUS_WIDTH(BW), .ACC_WIDTH(AW0)) bus0 ();
  mac_accum_if #(.BUS_WIDTH(BW), .ACC_WIDTH(AW1)) bus1 ();

  mac_accum #(.BUS_WIDTH(BW), .ACC_WIDTH(AW0), .COUNT(CNT0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  mac_accum #(.BUS_WIDTH(BW), .ACC_WIDTH(AW1), .COUNT(CNT1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct {
    int     id;
    int     edge_no;
    longint res;
    bit     ov;
  } exp_t;

  exp_t   pend[$];
  int     cyc    = 0;
  int     errors = 0;
  int     checks = 0;
  int     pcnt[2];
  longint psum[2];
  bit     psat[2];
  bit     v1m[2];
  longint last_res[2];
  bit     last_ov[2];
  int     pulses[2];

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: a dot product is the running sum of COUNT products, clamped after each add.
  task automatic model_edge(input int id, input bit v, input logic signed [7:0] a,
                            input logic signed [7:0] b, input bit c, input bit r);
    longint hi, lo, prod;
    int     n;
    n  = (id == 0) ? CNT0 : CNT1;
    hi = (64'sd1 <<< (((id == 0) ? AW0 : AW1) - 1)) - 1;
    lo = -hi - 1;
    if (r || c) begin
      pcnt[id] = 0;
      psum[id] = 0;
      psat[id] = 1'b0;
      v1m[id]  = 1'b0;
      for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].id == id) pend.delete(i);
      if (r) begin
        last_res[id] = 0;
        last_ov[id]  = 1'b0;
      end
    end else if (v) begin
      prod = longint'(a) * longint'(b);
      if (pcnt[id] == 0) begin
        psum[id] = prod;
        psat[id] = 1'b0;
      end else begin
        psum[id] = psum[id] + prod;
      end
      if (psum[id] > hi) begin
        psum[id] = hi;
        psat[id] = 1'b1;
      end else if (psum[id] < lo) begin
        psum[id] = lo;
        psat[id] = 1'b1;
      end
      pcnt[id]++;
      if (pcnt[id] == n) begin
        pend.push_back('{id: id, edge_no: cyc + 1, res: psum[id], ov: psat[id]});
        pcnt[id] = 0;
      end
      v1m[id] = 1'b1;
    end else begin
      v1m[id] = 1'b0;
    end
  endtask

  task automatic check_cycle(input int id);
    bit                 exp_ov;
    int                 hit;
    logic               o_v, o_ov, o_busy;
    logic signed [63:0] o_res;
    exp_ov = 1'b0;
    hit    = -1;
    for (int i = 0; i < pend.size(); i++)
      if (pend[i].id == id && pend[i].edge_no == cyc) hit = i;
    if (hit >= 0) begin
      exp_ov       = 1'b1;
      last_res[id] = pend[hit].res;
      last_ov[id]  = pend[hit].ov;
      pend.delete(hit);
    end
    if (id == 0) begin
      o_v = bus0.out_valid; o_res = bus0.result; o_ov = bus0.overflow; o_busy = bus0.busy;
    end else begin
      o_v = bus1.out_valid; o_res = bus1.result; o_ov = bus1.overflow; o_busy = bus1.busy;
    end
    chk($sformatf("d%0d.out_valid@%0d", id, cyc), {63'd0, o_v}, {63'd0, exp_ov});
    chk($sformatf("d%0d.result@%0d", id, cyc), o_res, last_res[id]);
    chk($sformatf("d%0d.overflow@%0d", id, cyc), {63'd0, o_ov}, {63'd0, last_ov[id]});
    chk($sformatf("d%0d.busy@%0d", id, cyc), {63'd0, o_busy},
        {63'd0, (v1m[id] || pcnt[id] > 0)});
    if (o_v === 1'b1) pulses[id]++;
  endtask

  task automatic step(input int id, input bit v, input logic signed [7:0] a,
                      input logic signed [7:0] b, input bit c, input bit r);
    rst           = r;
    bus0.in_valid = (id == 0) && v;
    bus0.a        = a;
    bus0.b        = b;
    bus0.clr      = (id == 0) && c;
    bus1.in_valid = (id == 1) && v;
    bus1.a        = a;
    bus1.b        = b;
    bus1.clr      = (id == 1) && c;
    @(posedge clk);
    cyc++;
    model_edge(0, (id == 0) && v, a, b, (id == 0) && c, r);
    model_edge(1, (id == 1) && v, a, b, (id == 1) && c, r);
    @(negedge clk);
    check_cycle(0);
    check_cycle(1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1'b0, 8'sd0, 8'sd0, 1'b0, 1'b0);
  endtask

  initial begin
    int p0, p1;
    for (int i = 0; i < 2; i++) begin
      pcnt[i] = 0; psum[i] = 0; psat[i] = 0; v1m[i] = 0;
      last_res[i] = 0; last_ov[i] = 0; pulses[i] = 0;
    end

    // Reset held with live operands
    for (int i = 0; i < 3; i++) step(0, 1'b1, 8'sd5, 8'sd5, 1'b0, 1'b1);
    idle(1);
    chk("rst.result", bus0.result, 0);
    chk("rst.busy", {63'd0, bus0.busy}, 0);

    // Basic sum
    p0 = pulses[0];
    for (int i = 1; i <= 8; i++) step(0, 1'b1, 8'(i), 8'sd2, 1'b0, 1'b0);
    idle(2);
    chk("basic.result", bus0.result, 72);
    chk("basic.pulses", pulses[0] - p0, 1);

    // Negative operands with gaps
    p0 = pulses[0];
    for (int i = 0; i < 8; i++) begin
      step(0, 1'b1, -8'sd128, 8'sd127, 1'b0, 1'b0);
      step(0, 1'b0, 8'sd0, 8'sd0, 1'b0, 1'b0);
    end
    idle(2);
    chk("neg.result", bus0.result, -130048);
    chk("neg.overflow", {63'd0, bus0.overflow}, 0);
    chk("neg.pulses", pulses[0] - p0, 1);

    // Back-to-back sums
    p0 = pulses[0];
    for (int i = 0; i < 16; i++) step(0, 1'b1, 8'sd3, -8'sd4, 1'b0, 1'b0);
    idle(2);
    chk("b2b.result", bus0.result, -96);
    chk("b2b.pulses", pulses[0] - p0, 2);

    // Saturation on the narrow instance, then a clean sum
    for (int i = 0; i < 4; i++) step(1, 1'b1, 8'sd127, 8'sd127, 1'b0, 1'b0);
    idle(2);
    chk("sat.result", bus1.result, 32767);
    chk("sat.overflow", {63'd0, bus1.overflow}, 1);
    for (int i = 0; i < 4; i++) step(1, 1'b1, 8'sd1, 8'sd1, 1'b0, 1'b0);
    idle(2);
    chk("sat2.result", bus1.result, 4);
    chk("sat2.overflow", {63'd0, bus1.overflow}, 0);

    // Abort mid-sum via clr, then via rst
    for (int k = 0; k < 2; k++) begin
      p0 = pulses[0];
      for (int i = 0; i < 5; i++) step(0, 1'b1, 8'sd10, 8'sd10, 1'b0, 1'b0);
      step(0, 1'b1, 8'sd10, 8'sd10, (k == 0), (k == 1));
      for (int i = 0; i < 8; i++) step(0, 1'b1, 8'sd1, 8'sd1, 1'b0, 1'b0);
      idle(2);
      chk($sformatf("abort%0d.result", k), bus0.result, 8);
      chk($sformatf("abort%0d.pulses", k), pulses[0] - p0, 1);
    end

    // Random traffic on both instances
    for (int i = 0; i < 250; i++)
      step(0, ($urandom_range(0, 3) != 0), 8'($urandom()), 8'($urandom()),
           ($urandom_range(0, 31) == 0), ($urandom_range(0, 149) == 0));
    p1 = pulses[1];
    for (int i = 0; i < 150; i++) begin
      logic signed [7:0] ra, rb;
      ra = ($urandom_range(0, 2) == 0) ? 8'($urandom()) : ($urandom_range(0, 1) ? 8'sd127 : -8'sd128);
      rb = ($urandom_range(0, 2) == 0) ? 8'($urandom()) : 8'sd127;
      step(1, ($urandom_range(0, 4) != 0), ra, rb, ($urandom_range(0, 39) == 0), 1'b0);
    end
    idle(3);
    chk("drain.pending", pend.size(), 0);
    chk("rand.sat_pulses_seen", {63'd0, (pulses[1] > p1)}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
